inout_mode_case: RTL and testbench

//  Mode-0 data-path core of an 8255-style programmable peripheral interface (PPI).

---
 rtl/inout_mode_case.sv | 116 +++++++++++
 tb/tb_inout_mode_case.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inout_mode_case.sv
// ----------------------------------------------------------------------------
// inout_mode_case
//   Mode-0 data-path core of an 8255-style programmable peripheral interface.
//   It holds the control word and the three port output latches. It also
//   steers the bidirectional CPU bus to and from ports A, B and C. Port C is
//   handled as two independent nibbles.
//
// Ports
//   clk    : system clock; all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   A      : register select (00=PortA, 01=PortB, 10=PortC, 11=control)
//   WRITE  : active-low CPU write strobe
//   READ   : active-low CPU read strobe
//   DATA   : bidirectional CPU data bus, driven only during a read cycle
//   PortA  : port A pins
//   PortB  : port B pins
//   PortC  : port C pins; [7:4] upper half, [3:0] lower half
//
// Control word: bit 7 = mode set, [4] PA dir, [3] PC upper dir, [1] PB dir,
// [0] PC lower dir (1 = input). Mode fields are stored and read back but the
// block always behaves as mode 0.
// ----------------------------------------------------------------------------
module inout_mode_case (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] A,
    input  logic       WRITE,
    input  logic       READ,
    inout  wire  [7:0] DATA,
    inout  wire  [7:0] PortA,
    inout  wire  [7:0] PortB,
    inout  wire  [7:0] PortC
);

    localparam logic [7:0] CW_RESET = 8'h9B;   // every port an input

    logic [7:0] cwReg;
    logic [7:0] laReg;
    logic [7:0] lbReg;
    logic [7:0] lcReg;

    logic       writeCycle;
    logic       readCycle;
    logic [7:0] readData;
    logic [1:0] cDirIn;      // {upper, lower} nibble direction, 1 = input
    logic [7:0] cReadVal;

    // Both strobes low together is illegal: neither a write nor a read.
    assign writeCycle = !WRITE && READ;
    assign readCycle  = !READ && WRITE;

    assign cDirIn = {cwReg[3], cwReg[0]};

    // ------------------------------------------------------------------
    // Control word and output latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cwReg <= CW_RESET;
            laReg <= 8'h00;
            lbReg <= 8'h00;
            lcReg <= 8'h00;
        end else if (writeCycle) begin
            case (A)
                2'b00: laReg <= DATA;
                2'b01: lbReg <= DATA;
                2'b10: lcReg <= DATA;
                default: begin
                    if (DATA[7]) begin
                        // Mode set clears every output latch on the same edge.
                        cwReg <= DATA;
                        laReg <= 8'h00;
                        lbReg <= 8'h00;
                        lcReg <= 8'h00;
                    end else begin
                        // Bit set/reset: one port C bit, control word untouched.
                        lcReg[DATA[3:1]] <= DATA[0];
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port pin drivers. An input-configured port floats so the outside
    // world can drive it; latches keep their contents regardless.
    // ------------------------------------------------------------------
    assign PortA = cwReg[4] ? 8'hzz : laReg;
    assign PortB = cwReg[1] ? 8'hzz : lbReg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gPortC
            assign PortC[gi*4 +: 4]    = cDirIn[gi] ? 4'hz : lcReg[gi*4 +: 4];
            // Input nibbles read live pins; output nibbles read back the latch.
            assign cReadVal[gi*4 +: 4] = cDirIn[gi] ? PortC[gi*4 +: 4]
                                                    : lcReg[gi*4 +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    always_comb begin
        readData = 8'h00;
        case (A)
            2'b00:   readData = cwReg[4] ? PortA : laReg;
            2'b01:   readData = cwReg[1] ? PortB : lbReg;
            2'b10:   readData = cReadVal;
            default: readData = cwReg;
        endcase
    end

    assign DATA = readCycle ? readData : 8'hzz;

endmodule

// File: tb/tb_inout_mode_case.sv
module tb_inout_mode_case;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] A;
    logic       WRITE;
    logic       READ;
    wire  [7:0] DATA;
    wire  [7:0] PortA;
    wire  [7:0] PortB;
    wire  [7:0] PortC;

    // Bench-side bus and pin drivers
    logic [7:0] drvData, drvA, drvB, drvC;
    logic       enData, enA, enB, enCHi, enCLo;

    assign DATA       = enData ? drvData    : 8'hzz;
    assign PortA      = enA    ? drvA       : 8'hzz;
    assign PortB      = enB    ? drvB       : 8'hzz;
    assign PortC[7:4] = enCHi  ? drvC[7:4]  : 4'hz;
    assign PortC[3:0] = enCLo  ? drvC[3:0]  : 4'hz;

    // Reference model state
    logic [7:0] cwM, laM, lbM, lcM;

    int errors = 0;
    int checks = 0;

    inout_mode_case dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .WRITE (WRITE),
        .READ  (READ),
        .DATA  (DATA),
        .PortA (PortA),
        .PortB (PortB),
        .PortC (PortC)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Bits set in inMask come from the pins, the rest from the latch.
    function automatic logic [7:0] mix(input logic [7:0] pin, input logic [7:0] lat,
                                       input logic [7:0] inMask);
        return (pin & inMask) | (lat & ~inMask);
    endfunction

    function automatic logic [7:0] maskFor(input logic [1:0] a);
        case (a)
            2'd0:    return {8{cwM[4]}};
            2'd1:    return {8{cwM[1]}};
            2'd2:    return {{4{cwM[3]}}, {4{cwM[0]}}};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] expRead(input logic [1:0] a);
        case (a)
            2'd0:    return mix(drvA, laM, maskFor(2'd0));
            2'd1:    return mix(drvB, lbM, maskFor(2'd1));
            2'd2:    return mix(drvC, lcM, maskFor(2'd2));
            default: return cwM;
        endcase
    endfunction

    function automatic void modelWrite(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd0: laM = d;
            2'd1: lbM = d;
            2'd2: lcM = d;
            default: begin
                if (d[7]) begin
                    cwM = d; laM = 8'h00; lbM = 8'h00; lcM = 8'h00;
                end else begin
                    lcM[d[3:1]] = d[0];
                end
            end
        endcase
    endfunction

    function automatic void modelReset();
        cwM = 8'h9B; laM = 8'h00; lbM = 8'h00; lcM = 8'h00;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic releasePins();
        enA = 1'b0; enB = 1'b0; enCHi = 1'b0; enCLo = 1'b0;
    endtask

    // Drive random values onto every pin group the model says is an input.
    task automatic applyPins();
        drvA = 8'($urandom); drvB = 8'($urandom); drvC = 8'($urandom);
        enA = cwM[4]; enB = cwM[1]; enCHi = cwM[3]; enCLo = cwM[0];
        #1;
    endtask

    // Entered and left at posedge+1 with both strobes high.
    task automatic doWrite(input logic [1:0] a, input logic [7:0] d);
        logic modeSet;
        modeSet = (a == 2'd3) && d[7];
        if (modeSet) releasePins();
        A = a; drvData = d; enData = 1'b1; WRITE = 1'b0;
        @(posedge clk); #1;
        WRITE = 1'b1; enData = 1'b0;
        modelWrite(a, d);
        if (modeSet) applyPins();
        $display("txn write A=%0d data=%02h", a, d);
    endtask

    task automatic startRead(input logic [1:0] a);
        A = a; READ = 1'b0; #1;
    endtask

    task automatic endRead();
        READ = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; WRITE = 1'b1; READ = 1'b1; A = 2'd0;
        enData = 1'b0; drvData = 8'h00; releasePins();
        drvA = 8'h00; drvB = 8'h00; drvC = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        startRead(2'd3);
        checks++;
        if (DATA !== 8'h9B) begin errors++; $display("FAIL reset_cw got=%02h exp=9B", DATA); end
        endRead();
        // Idle bus and input pins must float: a bench-driven value must read back intact.
        drvData = 8'h00; enData = 1'b1; #1;
        checks++;
        if (DATA !== 8'h00) begin errors++; $display("FAIL reset_data_z got=%02h exp=00", DATA); end
        enData = 1'b0;
        drvA = 8'hA5; drvB = 8'h5A; drvC = 8'h3C;
        enA = 1'b1; enB = 1'b1; enCHi = 1'b1; enCLo = 1'b1; #1;
        checks++;
        if (PortA !== 8'hA5) begin errors++; $display("FAIL reset_porta_z got=%02h exp=A5", PortA); end
        checks++;
        if (PortB !== 8'h5A) begin errors++; $display("FAIL reset_portb_z got=%02h exp=5A", PortB); end
        checks++;
        if (PortC !== 8'h3C) begin errors++; $display("FAIL reset_portc_z got=%02h exp=3C", PortC); end
        $display("txn reset done");
    endtask

    task automatic test_mode0_inputs();
        doWrite(2'd3, 8'h9B);
        enA = 1'b1; enB = 1'b1; enCHi = 1'b1; enCLo = 1'b1;
        startRead(2'd0);
        drvA = 8'hFF; #1;
        checks++;
        if (DATA !== 8'hFF) begin errors++; $display("FAIL in_porta_ff got=%02h exp=FF", DATA); end
        drvA = 8'h08; #1;
        checks++;
        if (DATA !== 8'h08) begin errors++; $display("FAIL in_porta_08 got=%02h exp=08", DATA); end
        A = 2'd1; drvB = 8'h09; #1;
        checks++;
        if (DATA !== 8'h09) begin errors++; $display("FAIL in_portb_09 got=%02h exp=09", DATA); end
        A = 2'd2; drvC = 8'h03; #1;
        checks++;
        if (DATA !== 8'h03) begin errors++; $display("FAIL in_portc_03 got=%02h exp=03", DATA); end
        drvC = 8'h02; #1;
        checks++;
        if (DATA !== 8'h02) begin errors++; $display("FAIL in_portc_02 got=%02h exp=02", DATA); end
        endRead();
        $display("txn mode0 input reads done");
    endtask

    task automatic test_output_latches();
        doWrite(2'd3, 8'h80);
        doWrite(2'd0, 8'h55);
        checks++;
        if (PortA !== 8'h55) begin errors++; $display("FAIL out_porta got=%02h exp=55", PortA); end
        doWrite(2'd2, 8'hA5);
        checks++;
        if (PortC !== 8'hA5) begin errors++; $display("FAIL out_portc got=%02h exp=A5", PortC); end
        doWrite(2'd1, 8'hC3);
        checks++;
        if (PortB !== 8'hC3) begin errors++; $display("FAIL out_portb got=%02h exp=C3", PortB); end
        startRead(2'd0);
        checks++;
        if (DATA !== 8'h55) begin errors++; $display("FAIL out_read_a got=%02h exp=55", DATA); end
        endRead();
    endtask

    task automatic test_bsr();
        doWrite(2'd3, 8'h07);
        checks++;
        if (PortC !== 8'hAD) begin errors++; $display("FAIL bsr_set3 got=%02h exp=AD", PortC); end
        doWrite(2'd3, 8'h06);
        checks++;
        if (PortC !== 8'hA5) begin errors++; $display("FAIL bsr_clr3 got=%02h exp=A5", PortC); end
        startRead(2'd3);
        checks++;
        if (DATA !== 8'h80) begin errors++; $display("FAIL bsr_cw_kept got=%02h exp=80", DATA); end
        endRead();
    endtask

    task automatic test_illegal();
        // Both strobes low: the DUT must not drive DATA nor update anything.
        A = 2'd0; drvData = 8'h3C; enData = 1'b1; WRITE = 1'b0; READ = 1'b0; #1;
        checks++;
        if (DATA !== 8'h3C) begin errors++; $display("FAIL illegal_data_z got=%02h exp=3C", DATA); end
        @(posedge clk); #1;
        A = 2'd3; drvData = 8'h9B;
        @(posedge clk); #1;
        WRITE = 1'b1; READ = 1'b1; enData = 1'b0;
        checks++;
        if (PortA !== 8'h55) begin errors++; $display("FAIL illegal_la_kept got=%02h exp=55", PortA); end
        startRead(2'd3);
        checks++;
        if (DATA !== 8'h80) begin errors++; $display("FAIL illegal_cw_kept got=%02h exp=80", DATA); end
        endRead();
        $display("txn illegal strobes done");
    endtask

    task automatic test_reset_during_write();
        A = 2'd0; drvData = 8'h77; enData = 1'b1; WRITE = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; WRITE = 1'b1; enData = 1'b0;
        modelReset();
        applyPins();
        checks++;
        if (PortA !== drvA) begin errors++; $display("FAIL rstwr_porta_z got=%02h exp=%02h", PortA, drvA); end
        startRead(2'd3);
        checks++;
        if (DATA !== 8'h9B) begin errors++; $display("FAIL rstwr_cw got=%02h exp=9B", DATA); end
        endRead();
        // Switch A only to output; the latch must hold the reset value, not 77.
        doWrite(2'd3, 8'h8B);
        checks++;
        if (PortA !== 8'h00) begin errors++; $display("FAIL rstwr_la got=%02h exp=00", PortA); end
        $display("txn reset during write done");
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [7:0] d, e;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    d = {1'b1, 7'($urandom)};
                    doWrite(2'd3, d);
                end
                1: begin
                    d = 8'($urandom) & 8'h7F;
                    doWrite(2'd3, d);
                end
                2: begin
                    a = 2'($urandom_range(0, 2));
                    d = 8'($urandom);
                    doWrite(a, d);
                end
                default: begin
                    applyPins();
                    a = 2'($urandom_range(0, 3));
                    startRead(a);
                    e = expRead(a);
                    checks++;
                    if (DATA !== e) begin
                        errors++;
                        $display("FAIL rnd_read A=%0d cw=%02h got=%02h exp=%02h", a, cwM, DATA, e);
                    end
                    $display("txn read A=%0d data=%02h", a, DATA);
                    endRead();
                end
            endcase
            e = mix(drvA, laM, maskFor(2'd0));
            checks++;
            if (PortA !== e) begin errors++; $display("FAIL rnd_porta cw=%02h got=%02h exp=%02h", cwM, PortA, e); end
            e = mix(drvB, lbM, maskFor(2'd1));
            checks++;
            if (PortB !== e) begin errors++; $display("FAIL rnd_portb cw=%02h got=%02h exp=%02h", cwM, PortB, e); end
            e = mix(drvC, lcM, maskFor(2'd2));
            checks++;
            if (PortC !== e) begin errors++; $display("FAIL rnd_portc cw=%02h got=%02h exp=%02h", cwM, PortC, e); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_inputs();
        test_output_latches();
        test_bsr();
        test_illegal();
        test_reset_during_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
